// File: rtl/reg_pipeline_pkg.sv
// Shared defaults for the fixed-latency register pipeline.
// Top-level parameters and the stage module take their defaults from here.
package reg_pipeline_pkg;

  localparam int PIPE_WIDTH = 16;
  localparam int PIPE_DEPTH = 4;

endpackage : reg_pipeline_pkg

// File: rtl/reg_pipeline_stage.sv
// One pipeline stage: a WIDTH-bit flop with asynchronous active-low clear.
// The output is the flop itself, so chained stages never form a combinational path.
module pipe_stage
  import reg_pipeline_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Capture the incoming word every edge; clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {WIDTH{1'b0}};
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule : pipe_stage

// File: rtl/reg_pipeline.sv
// Fixed-latency delay line: datain reaches dataout after exactly DEPTH rising edges.
// No enable or stall; reset clears every stage asynchronously and drops in-flight words.
module reg_pipeline
  import reg_pipeline_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = PIPE_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout
);

  if (WIDTH < 1) begin : g_width_chk
    $error("reg_pipeline: WIDTH must be at least 1");
  end

  if (DEPTH < 1) begin : g_depth_chk
    $error("reg_pipeline: DEPTH must be at least 1");
  end

  // chain_s[0] is the input; chain_s[i+1] is the output of stage i.
  logic [DEPTH:0][WIDTH-1:0] chain_s;

  assign chain_s[0] = datain;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (chain_s[i]),
      .q     (chain_s[i+1])
    );
  end

  assign dataout = chain_s[DEPTH];

endmodule : reg_pipeline

// File: tb/tb_reg_pipeline.sv
// Directed bench for reg_pipeline: default (16x4), DEPTH=1 and WIDTH=1/DEPTH=8 instances
// share one stimulus stream; expected outputs come from a history of driven words.
module tb_reg_pipeline;

  logic        clk;
  logic        rst_n;
  logic [15:0] datain;
  logic [15:0] dout4;
  logic [15:0] dout1;
  logic        dout8;

  int total;
  int bad;
  int cnt;
  bit in_rst;
  logic [15:0] hist [0:255];

  reg_pipeline dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .datain  (datain),
    .dataout (dout4)
  );

  reg_pipeline #(.WIDTH(16), .DEPTH(1)) dut_d1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .datain  (datain),
    .dataout (dout1)
  );

  reg_pipeline #(.WIDTH(1), .DEPTH(8)) dut_w1d8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .datain  (datain[0:0]),
    .dataout (dout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expect_at(input int depth);
    logic [15:0] w;
    if (in_rst || cnt < depth) begin
      expect_at = 16'h0000;
    end else begin
      w = hist[cnt-depth];
      expect_at = w;
    end
  endfunction

  task automatic check_all(input string tag);
    logic [15:0] e8;
    e8 = expect_at(8);
    chk({tag, "_d4"}, dout4, expect_at(4));
    chk({tag, "_d1"}, dout1, expect_at(1));
    chk({tag, "_w1d8"}, {15'h0000, dout8}, {15'h0000, e8[0]});
  endtask

  // Wait for the falling edge, check outputs, then present the next word.
  task automatic step(input string tag, input logic [15:0] w);
    @(negedge clk);
    check_all(tag);
    datain = w;
    hist[cnt] = w;
    cnt++;
  endtask

  task automatic release_rst(input logic [15:0] w);
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;
    in_rst = 1'b0;
    cnt = 0;
    datain = w;
    hist[0] = w;
    cnt = 1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    cnt    = 0;
    in_rst = 1'b1;
    rst_n  = 1'b1;
    datain = 16'hFFFF;
    #1 rst_n = 1'b0;

    // Reset held for 3 cycles with all-ones input: outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all("reset_val");
    end

    // Latency: single 1234 pulse followed by zeros.
    release_rst(16'h1234);
    for (int i = 0; i < 6; i++) step("latency", 16'h0000);
    @(negedge clk);
    check_all("latency_tail");
    datain = 16'hBEEF;
    hist[cnt] = 16'hBEEF;
    cnt++;

    // Streaming incrementing words; bit 0 toggles every cycle for the 1-bit instance.
    for (int i = 1; i <= 20; i++) step("stream", 16'(i));

    // Random words plus the named corner patterns.
    step("rand", 16'h0000);
    step("rand", 16'hFFFF);
    step("rand", 16'hA5A5);
    step("rand", 16'hBEEF);
    for (int i = 0; i < 20; i++) step("rand", 16'($urandom));
    for (int i = 0; i < 8; i++) step("drain", 16'h5A5A);

    // Mid-stream asynchronous reset, dropped between edges.
    @(posedge clk);
    #2;
    chk("pre_drop_d4", dout4, 16'h5A5A);
    rst_n  = 1'b0;
    in_rst = 1'b1;
    #1;
    chk("async_drop_d4", dout4, 16'h0000);
    chk("async_drop_d1", dout1, 16'h0000);
    chk("async_drop_w1d8", {15'h0000, dout8}, 16'h0000);
    datain = 16'hC3C3;
    release_rst(16'h0F0F);
    for (int i = 0; i < 12; i++) step("post_rst", 16'(16'h0100 + i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule : tb_reg_pipeline
